// File: rtl/soma_pkg.sv
// Shared types, segment constants and elaboration helpers for the soma_display block.
package soma_pkg;

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low segment pattern for one decimal digit, bit0 = segment a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Number of BCD nibbles needed to hold 2^width-1.
  function automatic int bcd_digits(input int width);
    longint v;
    int     n;
    v = (longint'(1) << width) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v > 9) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/soma_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, SW iterations per load.
module soma_bin2bcd
  import soma_pkg::*;
#(
  parameter int SW = 5,
  parameter int ND = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [SW-1:0]   bin_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [4*ND-1:0] bcd_o
);

  localparam int CW = $clog2(SW + 1);
  localparam int TW = 4 * ND + SW;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] shf_q, shf_d;
  logic [TW-1:0] adj, step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shf_q   <= shf_d;
    end
  end

  // Nibbles of 5..9 get +3 before the shift so they carry correctly into the next digit.
  always_comb begin
    adj = shf_q;
    for (int i = 0; i < ND; i++) begin
      if (shf_q[SW+4*i +: 4] >= 4'd5) adj[SW+4*i +: 4] = shf_q[SW+4*i +: 4] + 4'd3;
    end
    step = {adj[TW-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shf_d   = shf_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = CONVERT;
          cnt_d   = '0;
          shf_d   = {{(4*ND){1'b0}}, bin_i};
        end
      end
      CONVERT: begin
        shf_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SW - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // valid_o marks the final iteration; bcd_o is the result that edge will produce.
  always_comb begin
    busy_o  = (state_q == CONVERT);
    valid_o = (state_q == CONVERT) && (cnt_q == CW'(SW - 1));
    bcd_o   = step[TW-1:SW];
  end

endmodule

// File: rtl/soma_display.sv
// Adder + serial BCD conversion driving a multiplexed active-low 7-segment display.
// Optional macro SOMA_BLANK_EN blanks leading-zero digits.
module soma_display
  import soma_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int          SW   = WIDTH + 1;
  localparam int          ND   = bcd_digits(SW);
  localparam int          RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int          IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAXV = 64'(pow10(DIGITS) - 1);

  logic [SW-1:0]          sum, sum_q;
  logic                   load, cvt_busy, cvt_valid;
  logic [4*ND-1:0]        cvt_bcd;
  logic [4*(ND+DIGITS)-1:0] bcd_ext;
  logic                   unused_bcd;
  logic                   done_q, ovf_q;
  logic [4*DIGITS-1:0]    disp_q;
  logic [RW-1:0]          ref_q, ref_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [3:0]             cur;
  logic                   blank;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign load = start && !cvt_busy;

  soma_bin2bcd #(.SW(SW), .ND(ND)) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .bin_i   (sum),
    .busy_o  (cvt_busy),
    .valid_o (cvt_valid),
    .bcd_o   (cvt_bcd)
  );

  // Zero-extend so any DIGITS/ND combination can be sliced; digits beyond DIGITS are dropped.
  assign bcd_ext    = {{(4*DIGITS){1'b0}}, cvt_bcd};
  assign unused_bcd = ^bcd_ext[4*(ND+DIGITS)-1:4*DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      disp_q <= '0;
      sum_q  <= '0;
    end else begin
      done_q <= cvt_valid;
      if (load) sum_q <= sum;
      if (cvt_valid) begin
        disp_q <= bcd_ext[4*DIGITS-1:0];
        ovf_q  <= ({{(64-SW){1'b0}}, sum_q} > MAXV);
      end
    end
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= ~DIGITS'(1);
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      an_q  <= an_d;
    end
  end

  always_comb begin
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur = disp_q[4*i +: 4];
    end
  end

`ifdef SOMA_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero; units always shown.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead = lead && (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) blank = lead;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    if (ovf_q)      seg = SEG_DASH;
    else if (blank) seg = SEG_BLANK;
    else            seg = seg_decode(cur);
  end

  assign busy = cvt_busy;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign an   = an_q;

endmodule

// File: tb/tb_soma_display.sv
// Directed bench for soma_display: three configurations sharing one clock and reset.
module tb_soma_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       st4, busy4, done4, ovf4;
  logic [3:0] a4, b4;
  logic [6:0] seg4;
  logic [1:0] an4;

  logic       st3, busy3, done3, ovf3;
  logic [2:0] a3, b3;
  logic [6:0] seg3;
  logic [0:0] an3;

  logic       st8, busy8, done8, ovf8;
  logic [7:0] a8, b8;
  logic [6:0] seg8;
  logic [2:0] an8;

  int checks = 0;
  int failures = 0;

`ifdef SOMA_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  soma_display #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .ovf(ovf4), .seg(seg4), .an(an4));

  soma_display #(.WIDTH(3), .DIGITS(1), .REFRESH_DIV(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .ovf(ovf3), .seg(seg3), .an(an3));

  soma_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .ovf(ovf8), .seg(seg8), .an(an8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      3:       return busy3;
      8:       return busy8;
      default: return busy4;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      3:       return done3;
      8:       return done8;
      default: return done4;
    endcase
  endfunction

  function automatic logic [2:0] get_an(input int sel);
    case (sel)
      3:       return {2'b00, an3};
      8:       return an8;
      default: return {1'b0, an4};
    endcase
  endfunction

  // Called right after the start edge; counts busy cycles until done is seen.
  task automatic run(input int sel, output int bcyc, output logic got);
    bcyc = 0;
    got  = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (get_done(sel)) got = 1'b1;
      else begin
        if (get_busy(sel)) bcyc++;
        tick();
      end
    end
  endtask

  task automatic wait_an(input int sel, input logic [2:0] want, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (get_an(sel) == want) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int   bc, hold, nd;
    logic got, ok;

    rst_n = 1'b0;
    st4 = 0; a4 = 0; b4 = 0;
    st3 = 0; a3 = 0; b3 = 0;
    st8 = 0; a8 = 0; b8 = 0;
    tick(); tick();
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_seg", seg4, 7'h40);
    check("rst_an", an4, 2'b10);
    check("rst_an8", an8, 3'b110);
    rst_n = 1'b1;
    tick();

    // 9 + 8 = 17
    a4 = 4'd9; b4 = 4'd8; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    run(4, bc, got);
    check("basic_done_seen", got, 1);
    check("basic_busy_cycles", bc, 5);
    check("basic_busy_at_done", busy4, 0);
    check("basic_ovf", ovf4, 0);
    tick();
    check("basic_done_pulse", done4, 0);
    wait_an(4, 3'b001, ok);
    wait_an(4, 3'b010, ok);
    check("basic_an_units_seen", ok, 1);
    check("basic_seg_units", seg4, 7'h78);
    hold = 0;
    while (an4 == 2'b10 && hold < 20) begin hold++; tick(); end
    check("basic_hold_units", hold, 4);
    check("basic_an_tens", an4, 2'b01);
    check("basic_seg_tens", seg4, 7'h79);
    hold = 0;
    while (an4 == 2'b01 && hold < 20) begin hold++; tick(); end
    check("basic_hold_tens", hold, 4);

    // 3 + 4 = 7; start during busy with 1 + 1 must be ignored
    a4 = 4'd3; b4 = 4'd4; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    a4 = 4'd1; b4 = 4'd1; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    check("ign_busy_mid", busy4, 1);
    run(4, bc, got);
    check("ign_done_seen", got, 1);
    tick();
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done4) nd++;
      tick();
    end
    check("ign_no_second_done", nd, 0);
    check("ign_idle", busy4, 0);
    wait_an(4, 3'b010, ok);
    check("ign_seg_units", seg4, 7'h78);
    wait_an(4, 3'b001, ok);
    check("ign_seg_tens", seg4, LZ);

    // WIDTH=3, DIGITS=1: 7 + 5 = 12 overflows, then 2 + 3 = 5
    a3 = 3'd7; b3 = 3'd5; st3 = 1'b1;
    tick();
    st3 = 1'b0;
    run(3, bc, got);
    check("ovf_done_seen", got, 1);
    check("ovf_busy_cycles", bc, 4);
    check("ovf_flag", ovf3, 1);
    check("ovf_seg", seg3, 7'h3F);
    check("ovf_an", an3, 1'b0);
    a3 = 3'd2; b3 = 3'd3; st3 = 1'b1;
    tick();
    st3 = 1'b0;
    check("ovf_held_while_busy", ovf3, 1);
    run(3, bc, got);
    check("ovf_clear_done", got, 1);
    check("ovf_clear_flag", ovf3, 0);
    check("ovf_clear_seg", seg3, 7'h12);

    // WIDTH=8, DIGITS=3: 255 + 255 = 510
    a8 = 8'd255; b8 = 8'd255; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    run(8, bc, got);
    check("max_done_seen", got, 1);
    check("max_busy_cycles", bc, 9);
    check("max_ovf", ovf8, 0);
    wait_an(8, 3'b110, ok);
    check("max_seg_units", seg8, 7'h40);
    wait_an(8, 3'b101, ok);
    check("max_seg_tens", seg8, 7'h79);
    wait_an(8, 3'b011, ok);
    check("max_seg_hund", seg8, 7'h12);

    // 2 + 1 = 3: leading zeros
    a8 = 8'd2; b8 = 8'd1; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    run(8, bc, got);
    check("blank_done_seen", got, 1);
    wait_an(8, 3'b110, ok);
    check("blank_seg_units", seg8, 7'h30);
    wait_an(8, 3'b101, ok);
    check("blank_seg_tens", seg8, LZ);
    wait_an(8, 3'b011, ok);
    check("blank_seg_hund", seg8, LZ);

    // 15 + 15 aborted by reset two cycles into conversion
    a4 = 4'd15; b4 = 4'd15; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick(); tick();
    check("abort_busy_before", busy4, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 0);
    check("abort_seg", seg4, 7'h40);
    check("abort_an0", an4[0], 1'b0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done4) nd++;
      tick();
    end
    check("abort_no_done", nd, 0);
    check("abort_idle", busy4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
